// File: rtl/game_seq_ctrl.sv
// Sequencer for the 4x4 2048 board: owns the board register, runs move/spawn/check.
// Optional macro GAME_SEQ_MOVE_QUEUE_EN adds a one-entry buffer for requests made while busy.
module game_seq_ctrl #(
  parameter logic [11:0] WIN_VALUE  = 12'd2048,
  parameter int unsigned INIT_TILES = 2,
  parameter int unsigned GEN_WAIT   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    btn_valid,
  input  logic [1:0]              btn_dir,
  output logic [1:0]              mov_dir,
  output logic [0:3][0:3][11:0]   mov_board,
  input  logic [0:3][0:3][11:0]   mov_result,
  output logic [3:0]              gen_estado,
  output logic [0:3][0:3][11:0]   gen_board,
  input  logic [0:3][0:3][11:0]   gen_result,
  output logic [0:3][0:3][11:0]   matriz,
  output logic [2:0]              estado,
  output logic                    busy,
  output logic                    ganado,
  output logic                    perdido
);

  typedef logic [0:3][0:3][11:0] board_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MOVE   = 3'd1,
    S_SPAWN  = 3'd2,
    S_SETTLE = 3'd3,
    S_CHECK  = 3'd4,
    S_WIN    = 3'd5,
    S_LOSE   = 3'd6
  } state_t;

  localparam logic [3:0] GEN_INSERT = 4'b0100;
  localparam logic [3:0] GEN_IDLE   = 4'b0000;

  state_t      state_r, next_state_s;
  board_t      board_r;
  logic [3:0]  spawn_cnt_r;
  logic [7:0]  wait_cnt_r;
  logic [1:0]  mov_dir_r;
  logic [3:0]  gen_estado_r, gen_estado_s;
  logic        busy_r, busy_s;
  logic        ganado_r, ganado_s;
  logic        perdido_r, perdido_s;
  logic        gen_active_s, gen_last_s, moved_s;
  logic        start_s;
  logic [1:0]  start_dir_s;

  function automatic logic has_win(input board_t b);
    logic w;
    w = 1'b0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (b[r][c] >= WIN_VALUE) w = 1'b1;
    return w;
  endfunction

  // Lost only when the board is full and no slide could merge anything.
  function automatic logic has_lose(input board_t b);
    logic l;
    l = 1'b1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        if (b[r][c] == 12'd0) l = 1'b0;
        if (c < 3 && b[r][c] == b[r][c+1]) l = 1'b0;
        if (r < 3 && b[r][c] == b[r+1][c]) l = 1'b0;
      end
    return l;
  endfunction

  // The generator request is only counted once it is actually visible on gen_estado.
  assign gen_active_s = (state_r == S_SPAWN) && (gen_estado_r == GEN_INSERT);
  assign gen_last_s   = gen_active_s && (wait_cnt_r == 8'(GEN_WAIT - 1));
  assign moved_s      = (mov_result != board_r);

`ifdef GAME_SEQ_MOVE_QUEUE_EN
  logic       q_full_r;
  logic [1:0] q_dir_r;

  // Move start selection: a buffered request wins over a fresh one.
  always_comb begin
    start_s     = 1'b0;
    start_dir_s = mov_dir_r;
    if (state_r == S_IDLE && q_full_r) begin
      start_s     = 1'b1;
      start_dir_s = q_dir_r;
    end else if (state_r == S_IDLE && btn_valid) begin
      start_s     = 1'b1;
      start_dir_s = btn_dir;
    end else begin
      start_s     = 1'b0;
      start_dir_s = mov_dir_r;
    end
  end

  // Request buffer: captures requests while busy, emptied on consumption or game end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_full_r <= 1'b0;
      q_dir_r  <= 2'b00;
    end else if (next_state_s == S_WIN || next_state_s == S_LOSE) begin
      q_full_r <= 1'b0;
    end else if (state_r == S_IDLE && q_full_r) begin
      q_full_r <= btn_valid;
      if (btn_valid) q_dir_r <= btn_dir;
    end else if (btn_valid && state_r != S_IDLE && state_r != S_WIN && state_r != S_LOSE) begin
      q_full_r <= 1'b1;
      q_dir_r  <= btn_dir;
    end
  end
`else
  // Move start selection: requests are only honoured in IDLE.
  always_comb begin
    start_s     = 1'b0;
    start_dir_s = mov_dir_r;
    if (state_r == S_IDLE && btn_valid) begin
      start_s     = 1'b1;
      start_dir_s = btn_dir;
    end else begin
      start_s     = 1'b0;
      start_dir_s = mov_dir_r;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= S_SPAWN;
    else     state_r <= next_state_s;
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE:   next_state_s = start_s ? S_MOVE : S_IDLE;
      S_MOVE:   next_state_s = moved_s ? S_SPAWN : S_IDLE;
      S_SPAWN:  next_state_s = gen_last_s ? S_SETTLE : S_SPAWN;
      S_SETTLE: next_state_s = (spawn_cnt_r > 4'd1) ? S_SPAWN : S_CHECK;
      S_CHECK: begin
        if (has_win(board_r))       next_state_s = S_WIN;
        else if (has_lose(board_r)) next_state_s = S_LOSE;
        else                        next_state_s = S_IDLE;
      end
      S_WIN:    next_state_s = S_WIN;
      S_LOSE:   next_state_s = S_LOSE;
      default:  next_state_s = S_IDLE;
    endcase
  end

  // Output decode from the next state so the registered outputs line up with estado.
  always_comb begin
    gen_estado_s = (next_state_s == S_SPAWN) ? GEN_INSERT : GEN_IDLE;
    busy_s       = (next_state_s != S_IDLE);
    ganado_s     = (next_state_s == S_WIN);
    perdido_s    = (next_state_s == S_LOSE);
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gen_estado_r <= GEN_IDLE;
      busy_r       <= 1'b1;
      ganado_r     <= 1'b0;
      perdido_r    <= 1'b0;
    end else begin
      gen_estado_r <= gen_estado_s;
      busy_r       <= busy_s;
      ganado_r     <= ganado_s;
      perdido_r    <= perdido_s;
    end
  end

  // Board, direction and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      board_r     <= {16{12'h000}};
      spawn_cnt_r <= 4'(INIT_TILES);
      wait_cnt_r  <= 8'd0;
      mov_dir_r   <= 2'b00;
    end else begin
      if (start_s) mov_dir_r <= start_dir_s;
      if (state_r == S_MOVE && moved_s) begin
        board_r     <= mov_result;
        spawn_cnt_r <= 4'd1;
      end else if (gen_last_s) begin
        board_r <= gen_result;
      end else if (state_r == S_SETTLE) begin
        spawn_cnt_r <= spawn_cnt_r - 4'd1;
      end
      if (gen_last_s)        wait_cnt_r <= 8'd0;
      else if (gen_active_s) wait_cnt_r <= wait_cnt_r + 8'd1;
      else                   wait_cnt_r <= 8'd0;
    end
  end

  assign mov_dir    = mov_dir_r;
  assign mov_board  = board_r;
  assign gen_board  = board_r;
  assign matriz     = board_r;
  assign gen_estado = gen_estado_r;
  assign estado     = state_r;
  assign busy       = busy_r;
  assign ganado     = ganado_r;
  assign perdido    = perdido_r;

endmodule

// File: tb/tb_game_seq_ctrl.sv
// Directed bench for game_seq_ctrl with stub slide/merge and generator units.
module tb_game_seq_ctrl;

  typedef logic [0:3][0:3][11:0] board_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_valid = 1'b0;
  logic [1:0]  btn_dir = 2'b00;
  logic [1:0]  mov_dir;
  board_t      mov_board, mov_result, gen_board, gen_result, matriz;
  logic [3:0]  gen_estado;
  logic [2:0]  estado;
  logic        busy, ganado, perdido;

  logic        mov_force = 1'b0;
  board_t      mov_forced = '0;
  logic [1:0]  gen_mode = 2'd0;
  logic        found;
  board_t      exp_b, hold_b;
  int          n_vec = 0;
  int          n_err = 0;

  game_seq_ctrl dut (
    .clk(clk), .rst(rst), .btn_valid(btn_valid), .btn_dir(btn_dir),
    .mov_dir(mov_dir), .mov_board(mov_board), .mov_result(mov_result),
    .gen_estado(gen_estado), .gen_board(gen_board), .gen_result(gen_result),
    .matriz(matriz), .estado(estado), .busy(busy), .ganado(ganado), .perdido(perdido)
  );

  always #5 clk = ~clk;

  assign mov_result = mov_force ? mov_forced : mov_board;

  // Generator stub: 0 = a 2 in the first empty cell, 1 = 2048 at [2][2], else checkerboard.
  always_comb begin
    gen_result = gen_board;
    found = 1'b0;
    case (gen_mode)
      2'd0: begin
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++)
            if (!found && gen_board[r][c] == 12'd0) begin
              gen_result[r][c] = 12'd2;
              found = 1'b1;
            end
      end
      2'd1: gen_result[2][2] = 12'd2048;
      default: begin
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++)
            gen_result[r][c] = ((r + c) % 2 == 1) ? 12'd4 : 12'd2;
      end
    endcase
  end

  task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    btn_valid = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  initial begin
    // Reset and initial two-tile fill.
    gen_mode = 2'd0;
    tick();
    do_reset();
    chk("c0_estado", estado, 3'd2);
    chk("c0_gen", gen_estado, 4'b0000);
    chk("c0_busy", busy, 1'b1);
    chk("c0_board", matriz, '0);
    tick(); chk("c1_gen", gen_estado, 4'b0100); chk("c1_estado", estado, 3'd2);
    tick(); chk("c2_gen", gen_estado, 4'b0000); chk("c2_estado", estado, 3'd3);
    tick(); chk("c3_gen", gen_estado, 4'b0100); chk("c3_estado", estado, 3'd2);
    tick(); chk("c4_gen", gen_estado, 4'b0000); chk("c4_estado", estado, 3'd3);
    tick(); chk("c5_estado", estado, 3'd4);
    tick(); chk("c6_estado", estado, 3'd0); chk("c6_busy", busy, 1'b0);
    exp_b = '0; exp_b[0][0] = 12'd2; exp_b[0][1] = 12'd2;
    chk("init_board", matriz, exp_b);
    chk("mov_board_eq", mov_board, exp_b);
    chk("gen_board_eq", gen_board, exp_b);

    // Left move merging [0][0] and [0][1].
    mov_forced = '0; mov_forced[0][0] = 12'd4; mov_force = 1'b1;
    btn_dir = 2'b10; btn_valid = 1'b1;
    tick(); btn_valid = 1'b0;
    chk("mv_n1_estado", estado, 3'd1); chk("mv_n1_dir", mov_dir, 2'b10);
    tick();
    chk("mv_n2_cell", matriz[0][0], 12'd4); chk("mv_n2_gen", gen_estado, 4'b0100);
    chk("mv_n2_estado", estado, 3'd2);
    tick(); chk("mv_n3_estado", estado, 3'd3);
    tick(); chk("mv_n4_estado", estado, 3'd4);
    tick(); chk("mv_n5_estado", estado, 3'd0);
    exp_b = '0; exp_b[0][0] = 12'd4; exp_b[0][1] = 12'd2;
    chk("mv_board", matriz, exp_b);
    mov_force = 1'b0;

    // No-op move.
    btn_dir = 2'b01; btn_valid = 1'b1;
    tick(); btn_valid = 1'b0;
    chk("nop_n1_estado", estado, 3'd1); chk("nop_n1_gen", gen_estado, 4'b0000);
    chk("nop_n1_dir", mov_dir, 2'b01);
    tick(); chk("nop_n2_estado", estado, 3'd0); chk("nop_n2_gen", gen_estado, 4'b0000);
    chk("nop_board", matriz, exp_b);

    // Request during SPAWN.
    mov_forced = '0; mov_forced[0][0] = 12'd8; mov_force = 1'b1;
    btn_dir = 2'b11; btn_valid = 1'b1;
    tick(); btn_valid = 1'b0;
    tick(); chk("q_n2_estado", estado, 3'd2);
    btn_dir = 2'b00; btn_valid = 1'b1;
    tick(); btn_valid = 1'b0;
    tick();
    tick(); chk("q_n5_estado", estado, 3'd0);
    tick();
`ifdef GAME_SEQ_MOVE_QUEUE_EN
    chk("q_n6_estado", estado, 3'd1);
    chk("q_n6_dir", mov_dir, 2'b00);
    for (int i = 0; i < 20 && estado != 3'd0; i++) tick();
    chk("q_idle", estado, 3'd0);
`else
    chk("q_n6_estado", estado, 3'd0);
    chk("q_n6_dir", mov_dir, 2'b11);
    tick(); chk("q_n7_estado", estado, 3'd0);
`endif
    exp_b = '0; exp_b[0][0] = 12'd8; exp_b[0][1] = 12'd2;
    chk("q_board", matriz, exp_b);

    // Win via generator tile 2048.
    mov_forced = '0; mov_forced[0][0] = 12'd4;
    gen_mode = 2'd1;
    btn_dir = 2'b11; btn_valid = 1'b1;
    tick(); btn_valid = 1'b0;
    repeat (4) tick();
    chk("win_estado", estado, 3'd5); chk("win_ganado", ganado, 1'b1);
    chk("win_perdido", perdido, 1'b0); chk("win_busy", busy, 1'b1);
    exp_b = '0; exp_b[0][0] = 12'd4; exp_b[2][2] = 12'd2048;
    chk("win_board", matriz, exp_b);
    hold_b = matriz;
    btn_dir = 2'b00; btn_valid = 1'b1;
    tick(); btn_valid = 1'b0;
    repeat (3) tick();
    chk("win_hold_estado", estado, 3'd5); chk("win_hold_board", matriz, hold_b);
    chk("win_hold_dir", mov_dir, 2'b11); chk("win_hold_gen", gen_estado, 4'b0000);
    mov_force = 1'b0;

    // Lose via checkerboard from the generator.
    gen_mode = 2'd2;
    do_reset();
    repeat (6) tick();
    chk("lose_estado", estado, 3'd6); chk("lose_perdido", perdido, 1'b1);
    chk("lose_ganado", ganado, 1'b0);

    // Reset asserted mid-SPAWN.
    gen_mode = 2'd0;
    do_reset();
    tick(); chk("rs_pre_gen", gen_estado, 4'b0100);
    rst = 1'b1;
    tick();
    chk("rs_estado", estado, 3'd2); chk("rs_gen", gen_estado, 4'b0000);
    chk("rs_board", matriz, '0); chk("rs_dir", mov_dir, 2'b00);
    chk("rs_flags", {ganado, perdido, busy}, 3'b001);
    rst = 1'b0;
    repeat (6) tick();
    chk("rs_idle", estado, 3'd0);
    exp_b = '0; exp_b[0][0] = 12'd2; exp_b[0][1] = 12'd2;
    chk("rs_board2", matriz, exp_b);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/game_seq_ctrl.md
Name: game_seq_ctrl

Overview:
- Top-level sequencer for the 4x4 2048 board datapath.
- Owns the registered board and accepts direction requests from the button/debounce front end.
- Drives the external combinational slide/merge unit, then the random-tile generator, using the 4-bit request code (4'b0100 = insert, 4'b0000 = idle).
- Evaluates win/lose after every board update and presents the board and flags to the display logic.

Parameters:
- WIN_VALUE, 12'd2048, tile value that ends the game as won (any cell >= WIN_VALUE).
- INIT_TILES, 2, tiles inserted after reset before the first move is accepted (1..15).
- GEN_WAIT, 1, cycles the insert code is held before the generator result is captured (>=1).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- btn_valid  in  1  one-cycle move request strobe.
- btn_dir  in  2  move direction: 00 up, 01 down, 10 left, 11 right.
- mov_dir  out  2  latched direction to the slide/merge unit.
- mov_board  out  12x[0:3][0:3]  board presented to the slide/merge unit (= board register).
- mov_result  in  12x[0:3][0:3]  slide/merge output, combinational from mov_board/mov_dir.
- gen_estado  out  4  generator request code: 4'b0100 insert, 4'b0000 idle.
- gen_board  out  12x[0:3][0:3]  board presented to the generator (= board register).
- gen_result  in  12x[0:3][0:3]  generator output board with the new tile.
- matriz  out  12x[0:3][0:3]  registered board for display.
- estado  out  3  FSM state code.
- busy  out  1  high whenever state != IDLE.
- ganado  out  1  game won.
- perdido  out  1  game lost.

Behaviour:
- Reset values: board all 12'h000; mov_dir 00; gen_estado 4'b0000; ganado 0; perdido 0; spawn counter = INIT_TILES; state SPAWN (code 2). Reset asserted mid-operation aborts immediately to these values.
- State codes: IDLE 0, MOVE 1, SPAWN 2, SETTLE 3, CHECK 4, WIN 5, LOSE 6.
- IDLE:
  - btn_valid=1 latches btn_dir into mov_dir and goes to MOVE.
  - btn_valid is ignored in every other state (no queue unless the optional feature is enabled).
- MOVE (1 cycle):
  - If mov_result != board: board <= mov_result, spawn counter <= 1, go to SPAWN.
  - Otherwise: board is unchanged and the FSM returns to IDLE with no generator request.
- SPAWN:
  - gen_estado = 4'b0100 for GEN_WAIT cycles.
  - On the last of these cycles, board <= gen_result (taken verbatim), then go to SETTLE.
- SETTLE (1 cycle):
  - gen_estado = 4'b0000 and the spawn counter decrements.
  - Counter still > 0 after decrementing: go to SPAWN. Otherwise: go to CHECK.
  - Consecutive insert requests are therefore always separated by at least one idle code.
- CHECK (1 cycle):
  - Win: any cell >= WIN_VALUE -> WIN.
  - Lose: no cell equals 0 and no horizontally or vertically adjacent pair is equal -> LOSE.
  - Neither: IDLE.
  - If both win and lose hold, win takes priority.
- WIN / LOSE:
  - Terminal until rst; ganado (resp. perdido) = 1.
  - Board frozen; gen_estado 4'b0000; btn_valid ignored.
- Outputs: matriz = mov_board = gen_board = board register at all times. gen_estado is 4'b0100 only in SPAWN.
- Latency with GEN_WAIT=1, btn_valid in cycle N:
  - MOVE N+1, SPAWN N+2, SETTLE N+3, CHECK N+4, IDLE N+5.
  - A no-op move returns to IDLE at N+2.
- After reset: INIT_TILES SPAWN/SETTLE pairs, then CHECK, then IDLE.

Optional Feature:
- Macro: GAME_SEQ_MOVE_QUEUE_EN.
- Defined: a one-entry request buffer.
  - btn_valid while busy stores btn_dir; a later request overwrites an unconsumed one.
  - On entry to IDLE with the buffer full, the FSM goes to MOVE on the next cycle using the stored direction and clears the buffer.
  - Buffer cleared by rst and on entry to WIN/LOSE.
- Not defined: requests while busy are dropped; no buffer logic is built.

Test Plan:
- Reset with a generator stub placing 12'd2 in the first zero cell -> gen_estado sequence 0100,0000,0100,0000; then estado=4 for one cycle; then IDLE; matriz shows exactly two 12'd2 tiles; busy=0.
- Board {[0][0]=2,[0][1]=2}, btn_dir=10, mover stub returns [0][0]=4 -> mov_dir=10 at N+1; matriz [0][0]=4 at N+2; insert code at N+2; IDLE at N+5.
- No-op move (mov_result == board) -> no gen_estado 4'b0100 asserted; IDLE at N+2; board unchanged.
- btn_valid pulsed during SPAWN, macro undefined -> ignored, exactly one move executed. Macro defined -> second move starts one cycle after return to IDLE.
- Generator stub writes 12'd2048 at [2][2] -> ganado=1, estado=5; later btn_valid produces no change.
- Full board with alternating 2/4 checkerboard, no equal neighbours -> perdido=1, estado=6.
- rst asserted mid-SPAWN -> next edge shows all outputs at reset values and the init sequence restarts.
